// File: rtl/apb_pkg.sv
// Shared definitions for the word-aligned APB RAM: FSM state encoding and
// byte-lane geometry used by the interface, the top level and the RAM array.
`timescale 1ns/1ps
package apb_pkg;

  // Access sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } apb_state_e;

  // Number of byte strobes per word.
  localparam int APB_STB_W  = 4;
  // Width of one byte lane in bits.
  localparam int APB_LANE_W = 8;

endpackage

// File: rtl/apb_word_ram_if.sv
// Bus bundle between the unaligned-access splitter (master) and the
// word RAM (slave): aligned address, lane-positioned data, strobes,
// enable, plus the returned read data and ready pulse.
`timescale 1ns/1ps
interface apb_word_ram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import apb_pkg::*;

  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [APB_STB_W-1:0]  pstb;
  logic                  pwrite;
  logic                  penable;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;

  modport master (
    output paddr, pwdata, pstb, pwrite, penable,
    input  pready, prdata
  );

  modport slave (
    input  paddr, pwdata, pstb, pwrite, penable,
    output pready, prdata
  );

endinterface

// File: rtl/apb_word_ram_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, with per-byte write
// enables and a registered read port. Only the read register is reset.
`timescale 1ns/1ps
module apb_word_ram_array
  import apb_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [IDX_W-1:0]                 addr_i,
  input  logic                             we_i,
  input  logic [APB_STB_W-1:0]             be_i,
  input  logic [APB_STB_W*APB_LANE_W-1:0]  wdata_i,
  input  logic                             re_i,
  output logic [APB_STB_W*APB_LANE_W-1:0]  rdata_o
);

  localparam int DW = APB_STB_W * APB_LANE_W;

  logic [DW-1:0] mem [DEPTH_WORDS];
  logic [DW-1:0] rdata_q;

  // Byte-lane write into the storage array.
  // NOTE: the array has no reset; clearing every word would force it out of
  // RAM macros into flops, and software never relies on initial contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < APB_STB_W; i++) begin
        if (be_i[i]) begin
          mem[addr_i][i*APB_LANE_W +: APB_LANE_W] <= wdata_i[i*APB_LANE_W +: APB_LANE_W];
        end
      end
    end
  end

  // Registered read port; holds its value until the next read.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_word_ram.sv
// Word-aligned APB slave memory downstream of the unaligned-access splitter.
// Latches each request in IDLE, waits WAIT_STATES cycles, commits the access,
// pulses pready for one cycle in ACK and then parks in HOLD until penable
// falls, so each enable pulse produces exactly one access.
// Optional build macro APB_WORD_RAM_RANGE_CHK_EN: adds range_err and blocks
// accesses outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4); otherwise addresses
// alias modulo DEPTH_WORDS.
`timescale 1ns/1ps
module apb_word_ram
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter int                    WAIT_STATES = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic         APB_PCLK,
  input  logic         APB_PRESETn,
  apb_word_ram_if.slave bus
`ifdef APB_WORD_RAM_RANGE_CHK_EN
  ,
  output logic         range_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [APB_STB_W-1:0]  stb_q, stb_d;
  logic                  wr_q, wr_d;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  commit;
  logic                  access_ok;
  logic                  ram_we, ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Byte offset from the base; the word index drops the lane bits and keeps
  // only IDX_W bits, which is what makes out-of-window addresses alias.
  assign offset = bus.paddr - BASE_ADDR;
  assign commit = (state_q == WAIT) && (cnt_q == 4'd0);

`ifdef APB_WORD_RAM_RANGE_CHK_EN
  logic oor_q;
  logic rd_ok_q;
  logic range_err_q;
  logic in_range;

  assign in_range = (bus.paddr >= BASE_ADDR) &&
                    (offset < ADDR_WIDTH'(DEPTH_WORDS * 4));
  assign access_ok = ~oor_q;

  // Out-of-range flag captured with the request; range_err sets in ACK and
  // only reset clears it; rd_ok masks prdata after an out-of-range read.
  always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
    if (!APB_PRESETn) begin
      oor_q       <= 1'b0;
      rd_ok_q     <= 1'b1;
      range_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.penable) oor_q <= ~in_range;
      if (commit && !wr_q)                rd_ok_q <= access_ok;
      if (state_q == ACK && oor_q)        range_err_q <= 1'b1;
    end
  end

  assign range_err  = range_err_q;
  assign bus.prdata = ram_rdata & {DATA_WIDTH{rd_ok_q}};
`else
  assign access_ok  = 1'b1;
  assign bus.prdata = ram_rdata;
`endif

  // State and request registers; reset aborts any access in flight.
  always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
    if (!APB_PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      stb_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      stb_q   <= stb_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state, request latch and RAM strobes.
  // NOTE: every signal gets its default first (blocking =) so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    stb_d   = stb_q;
    wr_d    = wr_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.penable) begin
          idx_d   = IDX_W'(offset >> 2);
          wdata_d = bus.pwdata;
          stb_d   = bus.pstb;
          wr_d    = bus.pwrite;
          cnt_d   = 4'(WAIT_STATES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ram_we  = wr_q & access_ok;
          ram_re  = ~wr_q & access_ok;
          state_d = ACK;
        end
      end
      ACK:  state_d = HOLD;
      HOLD: if (!bus.penable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore completion pulse: decoded from the state register only.
  assign bus.pready = (state_q == ACK);

  apb_word_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (APB_PCLK),
    .rst_n   (APB_PRESETn),
    .addr_i  (idx_q),
    .we_i    (ram_we),
    .be_i    (stb_q),
    .wdata_i (wdata_q),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_apb_word_ram.sv
// Directed bench for apb_word_ram: two instances (WAIT_STATES=1 and 0,
// DEPTH_WORDS=16), a reference word model and a read-data scoreboard.
`timescale 1ns/1ps
module tb_apb_word_ram;
  import apb_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstb;
  logic        pwrite;
  logic        pen_a, pen_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [2][DEPTH];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  apb_word_ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_a ();
  apb_word_ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if_b ();

  assign if_a.paddr   = paddr;
  assign if_a.pwdata  = pwdata;
  assign if_a.pstb    = pstb;
  assign if_a.pwrite  = pwrite;
  assign if_a.penable = pen_a;
  assign if_b.paddr   = paddr;
  assign if_b.pwdata  = pwdata;
  assign if_b.pstb    = pstb;
  assign if_b.pwrite  = pwrite;
  assign if_b.penable = pen_b;

`ifdef APB_WORD_RAM_RANGE_CHK_EN
  logic range_err_a, range_err_b;
`endif

  apb_word_ram #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(1), .BASE_ADDR(32'h0)
  ) dut_a (
    .APB_PCLK    (clk),
    .APB_PRESETn (rst_n),
    .bus         (if_a)
`ifdef APB_WORD_RAM_RANGE_CHK_EN
    ,
    .range_err   (range_err_a)
`endif
  );

  apb_word_ram #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(0), .BASE_ADDR(32'h0)
  ) dut_b (
    .APB_PCLK    (clk),
    .APB_PRESETn (rst_n),
    .bus         (if_b)
`ifdef APB_WORD_RAM_RANGE_CHK_EN
    ,
    .range_err   (range_err_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
`ifdef APB_WORD_RAM_RANGE_CHK_EN
    return a < 32'(DEPTH * 4);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'(DEPTH - 1));
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    if (!in_range(a)) return 32'h0;
    return model[d][widx(a)];
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] w,
                             input logic [3:0] s);
    if (in_range(a)) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) model[d][widx(a)][i*8 +: 8] = w[i*8 +: 8];
    end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 0) ? if_a.pready : if_b.pready;
  endfunction

  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? if_a.prdata : if_b.prdata;
  endfunction

  task automatic set_en(input int d, input logic v);
    if (d == 0) pen_a = v; else pen_b = v;
  endtask

  // One APB access on instance d (0: WAIT_STATES=1, 1: WAIT_STATES=0).
  // Entered #1 after a rising edge; the request fields are scrambled after
  // the first cycle to show they were latched.
  task automatic access(input int d, input logic [31:0] a, input logic [31:0] w,
                        input logic [3:0] s, input logic wr, input string tag);
    int   ws  = (d == 0) ? 1 : 0;
    int   lat = 0;
    logic seen = 1'b0;
    paddr = a; pwdata = w; pstb = s; pwrite = wr;
    if (wr) model_write(d, a, w, s);
    else    exp_q.push_back(model_read(d, a));
    set_en(d, 1'b1);
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin paddr = a ^ 32'h4; pwdata = ~w; pstb = ~s; end
      seen = get_ready(d);
    end
    check({tag, "_latency"}, 32'(lat), 32'(ws + 2));
    if (!wr) check({tag, "_rdata"}, get_rdata(d), exp_q.pop_front());
    @(posedge clk); #1;
    set_en(d, 1'b0);
    check({tag, "_pulse"}, {31'b0, get_ready(d)}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [31:0] held;
    rst_n = 1'b0; pen_a = 1'b0; pen_b = 1'b0;
    paddr = '0; pwdata = '0; pstb = '0; pwrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pready_a", {31'b0, if_a.pready}, 32'h0);
    check("rst_prdata_a", if_a.prdata, 32'h0);
    check("rst_pready_b", {31'b0, if_b.pready}, 32'h0);
    check("rst_prdata_b", if_b.prdata, 32'h0);
`ifdef APB_WORD_RAM_RANGE_CHK_EN
    check("rst_range_err", {31'b0, range_err_a}, 32'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-word write and read-back, then a single-lane merge.
    access(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, "wr_full");
    access(0, 32'h10, 32'h0, 4'hF, 1'b0, "rd_full");
    access(0, 32'h10, 32'h00AA0000, 4'b0100, 1'b1, "wr_lane2");
    access(0, 32'h10, 32'h0, 4'h0, 1'b0, "rd_lane2");

    // Two splitter beats for a 4-byte write of 0x44332211 at byte 0x13.
    access(0, 32'h14, 32'h00000000, 4'hF, 1'b1, "wr_clr14");
    access(0, 32'h10, 32'h11000000, 4'b1000, 1'b1, "split_beat0");
    access(0, 32'h14, 32'h00443322, 4'b0111, 1'b1, "split_beat1");
    access(0, 32'h10, 32'h0, 4'hF, 1'b0, "split_rd10");
    access(0, 32'h14, 32'h0, 4'hF, 1'b0, "split_rd14");

    // Zero-strobe write completes and leaves the word alone.
    access(0, 32'h14, 32'hFFFFFFFF, 4'h0, 1'b1, "wr_nostb");
    access(0, 32'h14, 32'h0, 4'hF, 1'b0, "rd_nostb");

    // penable dropped while in WAIT: access still completes.
    paddr = 32'h24; pwdata = 32'h600DF00D; pstb = 4'hF; pwrite = 1'b1;
    model_write(0, 32'h24, 32'h600DF00D, 4'hF);
    pen_a = 1'b1;
    @(posedge clk); #1;
    pen_a = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (if_a.pready) pulses++;
    end
    check("drop_in_wait_pulses", 32'(pulses), 32'd1);
    access(0, 32'h24, 32'h0, 4'hF, 1'b0, "rd_drop");

    // Reset in WAIT discards an uncommitted write and clears outputs at once.
    access(0, 32'h20, 32'h12345678, 4'hF, 1'b1, "wr_pre20");
    access(0, 32'h20, 32'h0, 4'hF, 1'b0, "rd_pre20");
    paddr = 32'h20; pwdata = 32'hFFFFFFFF; pstb = 4'hF; pwrite = 1'b1;
    pen_a = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_pready", {31'b0, if_a.pready}, 32'h0);
    check("midrst_prdata", if_a.prdata, 32'h0);
    pen_a = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(0, 32'h20, 32'h0, 4'hF, 1'b0, "rd_after_rst");

    // Window edge: 0x40 aliases word 0, or is rejected with range checking.
    access(0, 32'h00, 32'hCAFEF00D, 4'hF, 1'b1, "wr_w0");
    access(0, 32'h40, 32'h0BADC0DE, 4'hF, 1'b1, "wr_40");
`ifdef APB_WORD_RAM_RANGE_CHK_EN
    check("range_err_set", {31'b0, range_err_a}, 32'h1);
`endif
    access(0, 32'h40, 32'h0, 4'hF, 1'b0, "rd_40");
    access(0, 32'h00, 32'h0, 4'hF, 1'b0, "rd_w0");
`ifdef APB_WORD_RAM_RANGE_CHK_EN
    check("range_err_sticky", {31'b0, range_err_a}, 32'h1);
    check("range_err_b_clear", {31'b0, range_err_b}, 32'h0);
`endif

    // Zero wait states: last word, then penable held 6 cycles past pready.
    access(1, 32'h3C, 32'hA5A55A5A, 4'hF, 1'b1, "b_wr_last");
    access(1, 32'h3C, 32'h0, 4'hF, 1'b0, "b_rd_last");
    held = if_b.prdata;
    check("b_prdata_held", held, 32'hA5A55A5A);
    paddr = 32'h08; pwdata = 32'h0000C0DE; pstb = 4'hF; pwrite = 1'b1;
    model_write(1, 32'h08, 32'h0000C0DE, 4'hF);
    pen_b = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (if_b.pready) pulses++;
    end
    check("b_hold_pulses", 32'(pulses), 32'd1);
    pen_b = 1'b0;
    @(posedge clk); #1;
    access(1, 32'h08, 32'h0, 4'hF, 1'b0, "b_rd_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
